// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmitter: FSM states, parity select, stop-bit select.
// No logic of its own; helpers are pure functions used by the transmitter.
// No flow control here; the transmitter and FIFO own all handshaking.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

    // data_xor is the XOR-reduction of the character (1 when it has an odd number of ones).
    function automatic logic parity_bit(input logic [1:0] ptype, input logic data_xor);
        return (ptype == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count driving full/empty/level.
// Latency: written entry visible at the head one cycle after the write edge.
// Backpressure: writes while full are dropped and flagged by a one-cycle overflow pulse.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_acc;
    logic             rd_acc;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // A full FIFO refuses the write even when a pop frees a slot on the same edge.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a character FIFO; frame = start, data LSB first, optional parity, 1-2 stops.
// Latency: write into an empty FIFO while idle and enabled drives the start bit two edges later.
// Backpressure: none upstream beyond full/level; writes while full are dropped with overflow_flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [1:0]                    parity_type,
    input  logic                          stop_bits,
    output logic                          data_tx,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          active_flag,
    output logic                          done_flag,
    output logic                          overflow_flag
);
    localparam int BIT_W = $clog2(DATA_W);

    state_t             state_q;
    logic [DIV_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic [BIT_W-1:0]   bit_idx_q;
    logic [DATA_W-1:0]  shift_q;
    logic               par_en_q;
    logic               par_q;
    logic               two_stop_q;
    logic               stop_idx_q;
    logic               done_pre_q;

    logic [DATA_W-1:0]  head;
    logic [DIV_W-1:0]   div_eff;
    logic               tick;
    logic               stop_end;
    logic               pop;
    logic               line_nxt;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow_flag)
    );

    assign div_eff     = (divisor == '0) ? DIV_W'(1) : divisor;
    assign tick        = (cnt_q == div_q);
    assign stop_end    = (state_q == ST_STOP) && tick && (!two_stop_q || stop_idx_q);
    assign pop         = enable && !empty && ((state_q == ST_IDLE) || stop_end);
    assign active_flag = (state_q != ST_IDLE);

    always_comb begin
        line_nxt = 1'b1;
        case (state_q)
            ST_START:  line_nxt = 1'b0;
            ST_DATA:   line_nxt = shift_q[0];
            ST_PARITY: line_nxt = par_q;
            default:   line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
            done_pre_q <= 1'b0;
            done_flag  <= 1'b0;
            data_tx    <= 1'b1;
        end else begin
            // The line is one register behind the FSM, so done is delayed to match it.
            data_tx    <= line_nxt;
            done_pre_q <= stop_end;
            done_flag  <= done_pre_q;

            if (pop) begin
                // Frame settings are captured here and frozen until the frame ends.
                state_q    <= ST_START;
                cnt_q      <= '0;
                div_q      <= div_eff;
                shift_q    <= head;
                par_en_q   <= parity_enabled(parity_type);
                par_q      <= parity_bit(parity_type, ^head);
                two_stop_q <= (stop_bits != STOP_ONE);
                stop_idx_q <= 1'b0;
            end else begin
                cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
                case (state_q)
                    ST_IDLE: cnt_q <= '0;
                    ST_START: if (tick) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                    end
                    ST_DATA: if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                            state_q    <= par_en_q ? ST_PARITY : ST_STOP;
                            stop_idx_q <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                        end
                    end
                    ST_PARITY: if (tick) begin
                        state_q    <= ST_STOP;
                        stop_idx_q <= 1'b0;
                    end
                    ST_STOP: if (tick) begin
                        if (stop_end) state_q    <= ST_IDLE;
                        else          stop_idx_q <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed corner cases plus randomized frames against a queue/bit-list model.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [15:0] divisor;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic        data_tx;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        active_flag;
    logic        done_flag;
    logic        overflow_flag;

    int n_chk;
    int n_bad;

    uart_tx_fifo #(
        .DATA_W     (8),
        .FIFO_DEPTH (16),
        .DIV_W      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .divisor       (divisor),
        .parity_type   (parity_type),
        .stop_bits     (stop_bits),
        .data_tx       (data_tx),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .active_flag   (active_flag),
        .done_flag     (done_flag),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] ch);
        wr_en   = 1'b1;
        wr_data = ch;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Expected line: one list entry per bit, each held for the effective bit period.
    task automatic expect_frame(input logic [7:0] ch, input int div, input logic [1:0] pt,
                                input bit two, input int max_wait);
        int   w;
        int   per;
        int   ones;
        logic bits[$];
        per = ((div < 1) ? 1 : div) + 1;
        w = 0;
        while (data_tx !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(ch[i]);
        ones = $countones(ch);
        if (pt == 2'b01) bits.push_back((ones % 2) == 0);
        else if (pt == 2'b10) bits.push_back((ones % 2) == 1);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < per; c++) begin
                check("line", int'(data_tx), int'(bits[b]));
                if (b != 0 || c != 0) check("done_mid", int'(done_flag), 0);
                @(negedge clk);
            end
        end
        check("done_end", int'(done_flag), 1);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] ch;
        int         n;
        int         d;
        logic [1:0] pt;
        bit         two;
        int         w;

        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        divisor = 16'd3;
        parity_type = 2'b00;
        stop_bits = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line", int'(data_tx), 1);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_level", int'(level), 0);
        check("rst_active", int'(active_flag), 0);
        check("rst_done", int'(done_flag), 0);
        check("rst_ovf", int'(overflow_flag), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 0xA5 frame with latency checks
        enable = 1'b1;
        push(8'hA5);
        check("lat_level", int'(level), 1);
        check("lat_line0", int'(data_tx), 1);
        @(negedge clk);
        check("lat_active", int'(active_flag), 1);
        check("lat_popped", int'(level), 0);
        check("lat_line1", int'(data_tx), 1);
        @(negedge clk);
        expect_frame(8'hA5, 3, 2'b00, 1'b0, 0);
        check("idle_line", int'(data_tx), 1);
        check("idle_active", int'(active_flag), 0);
        @(negedge clk);
        check("done_pulse_end", int'(done_flag), 0);

        // Parity and two stop bits
        parity_type = 2'b01;
        push(8'h03);
        expect_frame(8'h03, 3, 2'b01, 1'b0, 2);
        parity_type = 2'b10;
        push(8'h03);
        expect_frame(8'h03, 3, 2'b10, 1'b0, 2);
        parity_type = 2'b00;
        stop_bits = 1'b1;
        push(8'h5A);
        expect_frame(8'h5A, 3, 2'b00, 1'b1, 2);
        stop_bits = 1'b0;

        // Fill to 16, overflow on 17th, then pop+write while full
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            ch = 8'($urandom);
            q.push_back(ch);
            push(ch);
        end
        check("full_16", int'(full), 1);
        check("level_16", int'(level), 16);
        check("no_ovf_16", int'(overflow_flag), 0);
        push(8'hEE);
        check("ovf_17", int'(overflow_flag), 1);
        check("level_17", int'(level), 16);
        @(negedge clk);
        check("ovf_pulse", int'(overflow_flag), 0);
        enable = 1'b1;
        push(8'h77);
        check("ovf_with_pop", int'(overflow_flag), 1);
        check("level_pop", int'(level), 15);
        expect_frame(q.pop_front(), 3, 2'b00, 1'b0, 1);
        while (q.size() > 0) expect_frame(q.pop_front(), 3, 2'b00, 1'b0, 0);
        check("drain_empty", int'(empty), 1);
        check("drain_line", int'(data_tx), 1);

        // Three queued, write coinciding with the first pop
        enable = 1'b0;
        push(8'h11);
        push(8'h22);
        check("q_level2", int'(level), 2);
        enable = 1'b1;
        push(8'h33);
        check("wr_pop_level", int'(level), 2);
        expect_frame(8'h11, 3, 2'b00, 1'b0, 1);
        expect_frame(8'h22, 3, 2'b00, 1'b0, 0);
        expect_frame(8'h33, 3, 2'b00, 1'b0, 0);
        check("three_empty", int'(empty), 1);
        check("three_level", int'(level), 0);

        // Enable dropped mid-frame: frame completes, nothing else popped
        enable = 1'b0;
        push(8'hC3);
        push(8'h0F);
        enable = 1'b1;
        fork
            expect_frame(8'hC3, 3, 2'b00, 1'b0, 3);
            begin
                repeat (8) @(negedge clk);
                enable = 1'b0;
            end
        join
        check("hold_level", int'(level), 1);
        repeat (50) begin
            @(negedge clk);
            check("hold_line", int'(data_tx), 1);
            check("hold_active", int'(active_flag), 0);
        end

        // Reset during data bit 4 of 0x0F (bit value 0)
        push(8'h81);
        enable = 1'b1;
        @(negedge clk);
        w = 0;
        while (data_tx !== 1'b0 && w < 3) begin
            @(negedge clk);
            w++;
        end
        repeat (21) @(negedge clk);
        check("pre_rst_line", int'(data_tx), 0);
        rst_n = 1'b0;
        #1;
        check("arst_line", int'(data_tx), 1);
        check("arst_level", int'(level), 0);
        check("arst_empty", int'(empty), 1);
        check("arst_active", int'(active_flag), 0);
        check("arst_done", int'(done_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            check("post_rst_line", int'(data_tx), 1);
            check("post_rst_done", int'(done_flag), 0);
        end
        check("post_rst_level", int'(level), 0);

        // Divisor change mid-frame affects only the next frame
        enable = 1'b0;
        divisor = 16'd3;
        push(8'h96);
        push(8'h4B);
        enable = 1'b1;
        fork
            expect_frame(8'h96, 3, 2'b00, 1'b0, 2);
            begin
                repeat (12) @(negedge clk);
                divisor = 16'd7;
            end
        join
        expect_frame(8'h4B, 7, 2'b00, 1'b0, 0);

        // Randomized bursts
        for (int it = 0; it < 6; it++) begin
            enable = 1'b0;
            @(negedge clk);
            n   = $urandom_range(1, 4);
            d   = $urandom_range(0, 4);
            pt  = 2'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            divisor = 16'(d);
            parity_type = pt;
            stop_bits = two;
            for (int i = 0; i < n; i++) begin
                ch = 8'($urandom);
                q.push_back(ch);
                push(ch);
            end
            check("rnd_level", int'(level), n);
            enable = 1'b1;
            @(negedge clk);
            expect_frame(q.pop_front(), d, pt, two, 2);
            while (q.size() > 0) expect_frame(q.pop_front(), d, pt, two, 0);
            check("rnd_idle", int'(data_tx), 1);
            check("rnd_empty", int'(empty), 1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter DIV_W, default 16, width of the baud divisor input.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  permits new frames to start.
REQ-007 SHALL have port wr_en  input  1  write strobe into FIFO.
REQ-008 SHALL have port wr_data  input  DATA_W  character to queue.
REQ-009 SHALL have port divisor  input  DIV_W  bit period minus one, in clk cycles (bit period = divisor+1; values below 1 are treated as 1).
REQ-010 SHALL have port parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-011 SHALL have port stop_bits  input  1  0 one stop bit, 1 two stop bits.
REQ-012 SHALL have port data_tx  output  1  serial line, idle high.
REQ-013 SHALL have port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-014 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-015 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 SHALL have port active_flag  output  1  high while a frame is on the line.
REQ-017 SHALL have port done_flag  output  1  one-cycle pulse at end of each frame.
REQ-018 SHALL have port overflow_flag  output  1  one-cycle pulse when a write is dropped.

Function
REQ-019 Frame SHALL be: start bit (0), DATA_W data bits LSB first, optional parity bit, 1 or 2 stop bits (1); each bit held exactly divisor+1 cycles.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when parity_type is 00 or 11.
REQ-021 IDLE->START SHALL occur when enable=1 and empty=0; the FIFO head is popped on the same edge.
REQ-022 divisor, parity_type, stop_bits SHALL be sampled at IDLE->START and held for the whole frame; mid-frame changes have no effect.
REQ-023 Odd parity SHALL make total ones in data+parity odd; even parity SHALL make it even.
REQ-024 Latency: write accepted at edge E into an empty FIFO while IDLE and enabled -> data_tx low after edge E+2.
REQ-025 At end of last stop bit, done_flag SHALL pulse one cycle; if enable=1 and FIFO not empty the FSM SHALL go directly to START (no idle cycle), else to IDLE.
REQ-026 active_flag SHALL be 1 in START, DATA, PARITY, STOP and 0 in IDLE.
REQ-027 enable deasserted mid-frame SHALL let the current frame complete; no further pops occur.
REQ-028 Write with full=1 SHALL be dropped and overflow_flag SHALL pulse, even if a pop occurs on the same edge.
REQ-029 Write and pop on the same edge with full=0 SHALL leave level unchanged and store the new character.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty/level SHALL derive from a registered count.
REQ-031 data_tx SHALL be registered (glitch-free).

Reset
REQ-032 rst_n low SHALL asynchronously force: data_tx=1, FSM=IDLE, FIFO emptied (empty=1, full=0, level=0), active_flag=0, done_flag=0, overflow_flag=0.
REQ-033 Reset mid-frame SHALL abort the frame immediately with no done_flag pulse; queued characters are discarded.
REQ-034 First frame after reset release SHALL require a new write.

Structure
REQ-035 Package uart_pkg SHALL hold the FSM state enum, parity_type encoding constants and stop-bit encoding.
REQ-036 FIFO SHALL be a separate sub-module uart_sync_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification
REQ-037 DATA_W=8, divisor=3, parity 00, 1 stop, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done_flag pulse at cycle 40 after start.
REQ-038 parity 01 with 0x03 -> parity bit 1; parity 10 with 0x03 -> parity bit 0; stop_bits=1 -> stop held 8 cycles at divisor=3.
REQ-039 Write 17 characters back-to-back with FIFO_DEPTH=16, enable=0 -> full=1 after 16, 17th gives overflow_flag pulse, level=16.
REQ-040 Enable with 3 queued -> three frames with no idle gap, done_flag three pulses, empty=1 after third pop.
REQ-041 Assert rst_n low during DATA bit 4 -> data_tx=1 same cycle, level=0, no done_flag; after release line stays idle.
REQ-042 Change divisor from 3 to 7 mid-frame -> current frame keeps 4-cycle bits, next frame uses 8-cycle bits.
